// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and widths for the instruction-fetch stage
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_OUT    = 3'd2,
    ST_SQUASH = 3'd3,
    ST_HALT   = 3'd4
  } fetch_state_e;

  function automatic logic [OP_MSB-OP_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_unit_if : instruction-memory, redirect and decode handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if import fetch_pkg::*; ();

  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_rdy;
  logic [INSTR_W-1:0]  imem_data;
  logic                redirect;
  logic [PC_W-1:0]     redirect_pc;
  logic                if_valid;
  logic                if_ready;
  logic [INSTR_W-1:0]  if_instr;
  logic [PC_W-1:0]     if_pc;
  logic [PC_W-1:0]     if_pc_next;
  logic                halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_next, halted,
    input  imem_rdy, imem_data, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_next, halted,
    output imem_rdy, imem_data, redirect, redirect_pc, if_ready
  );

endinterface
`default_nettype wire

// File: rtl/adder_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_16 : 16-bit unsigned adder, carry-out discarded (wraps mod 2^16)
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc_unit : PC register, variable-latency imem fetch, decode hand-off
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC   = 16'd2,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_unit_if.master bus
);

  localparam logic [PC_W-1:0] RESET_PC_NEXT = RESET_PC + PC_INC;

  fetch_state_e         state_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      tgt_q;
  logic [PC_W-1:0]      addr_q;
  logic                 req_q;
  logic                 valid_q;
  logic                 halted_q;
  logic [INSTR_W-1:0]   if_instr_q;
  logic [PC_W-1:0]      if_pc_q;
  logic [PC_W-1:0]      if_pc_next_q;
  logic [PC_W-1:0]      pc_inc_w;

  adder_16 u_pc_adder (
    .a_i   (pc_q),
    .b_i   (PC_INC),
    .sum_o (pc_inc_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      tgt_q        <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= RESET_PC;
      if_pc_next_q <= RESET_PC_NEXT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end

        ST_REQ: begin
          if (bus.imem_rdy && bus.redirect) begin
            pc_q   <= bus.redirect_pc;
            addr_q <= bus.redirect_pc;
          end else if (bus.imem_rdy) begin
            state_q      <= ST_OUT;
            req_q        <= 1'b0;
            valid_q      <= 1'b1;
            if_instr_q   <= bus.imem_data;
            if_pc_q      <= pc_q;
            if_pc_next_q <= pc_inc_w;
          end else if (bus.redirect) begin
            state_q <= ST_SQUASH;
            tgt_q   <= bus.redirect_pc;
          end
        end

        // The in-flight request must complete before the target is fetched;
        // a redirect coinciding with that completion is the newest target.
        ST_SQUASH: begin
          if (bus.imem_rdy) begin
            state_q <= ST_REQ;
            pc_q    <= bus.redirect ? bus.redirect_pc : tgt_q;
            addr_q  <= bus.redirect ? bus.redirect_pc : tgt_q;
          end else if (bus.redirect) begin
            tgt_q <= bus.redirect_pc;
          end
        end

        ST_OUT: begin
          if (bus.redirect) begin
            state_q <= ST_REQ;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            pc_q    <= bus.redirect_pc;
            addr_q  <= bus.redirect_pc;
          end else if (bus.if_ready && (opcode_of(if_instr_q) == HALT_OP)) begin
            state_q  <= ST_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (bus.if_ready) begin
            state_q <= ST_REQ;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            pc_q    <= pc_inc_w;
            addr_q  <= pc_inc_w;
          end
        end

        ST_HALT: begin
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.if_valid   = valid_q;
  assign bus.if_instr   = if_instr_q;
  assign bus.if_pc      = if_pc_q;
  assign bus.if_pc_next = if_pc_next_q;
  assign bus.halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit : vector table, directed corner sequences, random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

  logic clk;
  logic rst_n;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .PC_INC   (16'd2),
    .RESET_PC (16'h0000),
    .HALT_OP  (4'hF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  logic        halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0010;

  // Memory image: unique per even address, opcode MSB clear so never a halt
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {1'b0, a[15:1]};
  endfunction

  always_comb begin
    bus.imem_data = mem_word(bus.imem_addr);
    if (halt_en && bus.imem_addr == halt_addr)
      bus.imem_data = 16'hF000;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic dec, input logic redir, input logic [15:0] rpc);
    bus.imem_rdy    = rdy;
    bus.if_ready    = dec;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic step(input logic rdy, input logic dec, input logic redir, input logic [15:0] rpc);
    drive(rdy, dec, redir, rpc);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        dec;
    logic        redir;
    logic [15:0] rpc;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic [15:0] exp_pcn;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] rpc;
    logic [31:0] rnd;
    logic        rdy, dec, redir;
    logic        prev_stall;
    logic [15:0] prev_addr;
    int          accepted;

    // outputs checked first, then the row's inputs are driven for one edge
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0002};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000, 16'h0002};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0001, 16'h0002, 16'h0004};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0001, 16'h0002, 16'h0004};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0004, 1'b1, 16'h0002, 16'h0004, 16'h0006};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0002, 16'h0004, 16'h0006};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b1, 16'h0080, 16'h0100, 16'h0102};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("reset_halted", {15'd0, bus.halted}, 16'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("vec%0d_req", i),   {15'd0, bus.imem_req}, {15'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i),  bus.imem_addr,         vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), {15'd0, bus.if_valid}, {15'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_instr", i), bus.if_instr,          vecs[i].exp_instr);
      chk($sformatf("vec%0d_pc", i),    bus.if_pc,             vecs[i].exp_pc);
      chk($sformatf("vec%0d_pcn", i),   bus.if_pc_next,        vecs[i].exp_pcn);
      step(vecs[i].rdy, vecs[i].dec, vecs[i].redir, vecs[i].rpc);
    end

    // Slow memory: address held over a four-cycle request
    do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("slow_req0", {15'd0, bus.imem_req}, 16'd1);
    chk("slow_addr0", bus.imem_addr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("slow_req", {15'd0, bus.imem_req}, 16'd1);
      chk("slow_addr", bus.imem_addr, 16'h0000);
      chk("slow_novalid", {15'd0, bus.if_valid}, 16'd0);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("slow_valid", {15'd0, bus.if_valid}, 16'd1);
    chk("slow_pc", bus.if_pc, 16'h0000);

    // Decode back-pressure
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("stall_valid", {15'd0, bus.if_valid}, 16'd1);
      chk("stall_instr", bus.if_instr, 16'h0000);
      chk("stall_pc", bus.if_pc, 16'h0000);
      chk("stall_noreq", {15'd0, bus.imem_req}, 16'd0);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("accept_req", {15'd0, bus.imem_req}, 16'd1);
    chk("accept_addr", bus.imem_addr, 16'h0002);

    // Two redirects against a stalled request: last one wins, data squashed
    step(1'b0, 1'b0, 1'b1, 16'h0100);
    chk("sq1_req", {15'd0, bus.imem_req}, 16'd1);
    chk("sq1_addr", bus.imem_addr, 16'h0002);
    step(1'b0, 1'b0, 1'b1, 16'h0200);
    chk("sq2_addr", bus.imem_addr, 16'h0002);
    chk("sq2_valid", {15'd0, bus.if_valid}, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sq3_valid", {15'd0, bus.if_valid}, 16'd0);
    chk("sq3_req", {15'd0, bus.imem_req}, 16'd1);
    chk("sq3_addr", bus.imem_addr, 16'h0200);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sq4_valid", {15'd0, bus.if_valid}, 16'd1);
    chk("sq4_pc", bus.if_pc, 16'h0200);
    chk("sq4_instr", bus.if_instr, 16'h0100);

    // Halt at 0x0010, then redirect must be ignored
    halt_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 16'h0010);
    chk("h_addr", bus.imem_addr, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("h_instr", bus.if_instr, 16'hF000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("h_halted", {15'd0, bus.halted}, 16'd1);
    chk("h_noreq", {15'd0, bus.imem_req}, 16'd0);
    chk("h_novalid", {15'd0, bus.if_valid}, 16'd0);
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      chk("h_stay_halted", {15'd0, bus.halted}, 16'd1);
      chk("h_stay_noreq", {15'd0, bus.imem_req}, 16'd0);
    end

    // Redirect coinciding with halt acceptance wins
    do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("hr_instr", bus.if_instr, 16'hF000);
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    chk("hr_halted", {15'd0, bus.halted}, 16'd0);
    chk("hr_req", {15'd0, bus.imem_req}, 16'd1);
    chk("hr_addr", bus.imem_addr, 16'h0040);
    halt_en = 1'b0;

    // PC wrap, then asynchronous reset in the middle of a squash
    step(1'b0, 1'b0, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wrap_addr", bus.imem_addr, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", bus.if_pc, 16'hFFFE);
    chk("wrap_pcn", bus.if_pc_next, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("wrap_next_addr", bus.imem_addr, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0300);
    chk("ar_pre_req", {15'd0, bus.imem_req}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", {15'd0, bus.imem_req}, 16'd0);
    chk("ar_addr", bus.imem_addr, 16'h0000);
    chk("ar_valid", {15'd0, bus.if_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_idle_req", {15'd0, bus.imem_req}, 16'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ar_first_req", {15'd0, bus.imem_req}, 16'd1);
    chk("ar_first_addr", bus.imem_addr, 16'h0000);

    // Random traffic against the in-order-delivery model
    do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    exp_pc     = 16'h0000;
    prev_stall = 1'b0;
    prev_addr  = 16'h0000;
    accepted   = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_stall) begin
        chk("rnd_req_hold", {15'd0, bus.imem_req}, 16'd1);
        chk("rnd_addr_hold", bus.imem_addr, prev_addr);
      end
      rdy   = bus.imem_req && ($urandom_range(0, 2) != 0);
      dec   = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 9) == 0);
      rnd   = $urandom;
      rpc   = ($urandom_range(0, 7) == 0) ? 16'hFFFE : {rnd[15:1], 1'b0};
      if (redir) begin
        exp_pc = rpc;
      end else if (bus.if_valid && dec) begin
        chk("rnd_pc", bus.if_pc, exp_pc);
        chk("rnd_instr", bus.if_instr, mem_word(exp_pc));
        chk("rnd_pcn", bus.if_pc_next, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2;
        accepted++;
      end
      prev_stall = bus.imem_req && !rdy;
      prev_addr  = bus.imem_addr;
      step(rdy, dec, redir, rpc);
    end
    chk("rnd_progress", {15'd0, (accepted >= 200)}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
